captura_producto: RTL
=====================

# captura_producto

Result-capture stage sitting directly downstream of the iterative 32x32 multiplier. It completes the multiplier's `Done_Flag`/`ack` handshake, stores each accepted 64-bit product in a small show-ahead FIFO for a downstream consumer, and keeps a running sum of all accepted products. It is the only agent that drives the multiplier's `ack`. A full FIFO stalls the multiplier by withholding `ack`.

## Interface

- `WIDTH`, 64: product width; must match the multiplier's product output.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `ACC_WIDTH`, 72: running-sum width; at least `WIDTH`.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low; sampled on rising `clk`.
- `producto`  in  WIDTH  multiplier product; stable while `Done_Flag`=1.
- `Done_Flag`  in  1  multiplier result ready; held high until `ack` is seen.
- `ack`  out  1  registered acknowledge to the multiplier.
- `rd_en`  in  1  consumer pop request.
- `dato`  out  WIDTH  FIFO head (show-ahead); 0 when empty.
- `vacio`  out  1  FIFO empty.
- `lleno`  out  1  FIFO full.
- `cuenta`  out  log2(DEPTH)+1  entries held.
- `clr_suma`  in  1  clear the running sum and overflow flag.
- `suma`  out  ACC_WIDTH  running sum of accepted products.
- `desborde`  out  1  sticky; set when `suma` wraps.

## Operation

- Reset (`reset`=0 at an edge): state ESPERA, `ack`=0, read/write pointers 0, `cuenta`=0, `vacio`=1, `lleno`=0, `suma`=0, `desborde`=0, `dato`=0. Reset takes priority over every other input.
- Handshake FSM, two states:
  - ESPERA: `ack`=0. If `Done_Flag`=1 and `lleno`=0 at the edge, capture: write `producto` at the write pointer and add it to `suma`, then go to ACK. If `lleno`=1, stay in ESPERA; the multiplier stalls.
  - ACK: `ack`=1. Stay in ACK while `Done_Flag`=1; nothing further is captured. When `Done_Flag`=0 is sampled, go to ESPERA.
  - Exactly one capture per `Done_Flag` assertion, however long the multiplier holds it.
- FIFO:
  - Pop occurs when `rd_en`=1 and `vacio`=0. `rd_en` on an empty FIFO is ignored.
  - Push and pop in the same cycle: `cuenta` is unchanged and both pointers advance.
  - Push is gated on `lleno` as registered at that edge. A same-cycle pop does not free a slot for the push.
  - Pointers wrap modulo `DEPTH`.
- Sum arithmetic:
  - On capture, `suma` <= `suma` + zero-extended `producto`, modulo 2^`ACC_WIDTH`. A carry out sets `desborde`.
  - `clr_suma`=1 zeroes `suma` and `desborde`. If a capture happens in the same cycle, `suma` <= `producto` and `desborde`=0.

## Timing

- Capture edge N: FIFO write, `suma` update and the ESPERA->ACK transition all occur at edge N. `ack`, `cuenta`, `vacio` and `dato` reflect the capture after edge N.
- `ack` falls after the first edge at which `Done_Flag`=0 is sampled. Next capture is possible at the following edge at the earliest, so a back-to-back product costs at least 2 cycles.
- `dato` is driven combinationally from registered storage and the read pointer. No read latency: the head is valid whenever `vacio`=0.
- `lleno` and `vacio` are derived from `cuenta`. Both are registered-path signals with no combinational path from `rd_en` or `Done_Flag`.
- Reset mid-handshake (in ACK): `ack` drops immediately after the reset edge and the FIFO contents are discarded. If `Done_Flag` is still 1 after reset release, it is a new product and is captured again. The multiplier shares the same reset, so this does not happen in the integrated system.

## Test plan

- Reset, then `producto`=96 (32×3) with `Done_Flag` held 5 cycles -> one capture, `ack`=1 for the remainder of `Done_Flag` high, `dato`=96, `cuenta`=1, `suma`=96.
- After the first product, `producto`=25 (5×5) -> `suma`=121. Pop twice -> `dato` sequence 96, 25; then `vacio`=1, `dato`=0.
- Push 4 products (1, 2, 3, 4) without popping, then present a fifth (5) -> `lleno`=1 and `ack` stays 0. One pop -> 5 is captured on the next edge. Subsequent pops yield 2, 3, 4, 5.
- `ACC_WIDTH`=64: capture 2^63 twice -> `suma`=0, `desborde`=1. Then assert `clr_suma` together with a capture of 7 -> `suma`=7, `desborde`=0.
- Simultaneous push and pop with `cuenta`=2 -> `cuenta` stays 2 and FIFO order is preserved. `rd_en` held while empty -> `cuenta` stays 0 with no pointer movement.
- Assert `reset`=0 while in ACK with `Done_Flag`=1 -> after the edge, `ack`=0, `cuenta`=0, `suma`=0. Release reset with `Done_Flag` still 1 -> re-capture, `cuenta`=1.

Source files
------------

// File: rtl/captura_producto.sv
// Result-capture stage behind the iterative multiplier: completes the Done_Flag/ack
// handshake, queues each product in a show-ahead FIFO and keeps a running sum.
module captura_producto #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 4,
    parameter int ACC_WIDTH = 72
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           producto,
    input  logic                       Done_Flag,
    output logic                       ack,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dato,
    output logic                       vacio,
    output logic                       lleno,
    output logic [$clog2(DEPTH):0]     cuenta,
    input  logic                       clr_suma,
    output logic [ACC_WIDTH-1:0]       suma,
    output logic                       desborde
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] ESPERA = 1'b0;
    localparam logic [0:0] ACK    = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cuenta_q, cuenta_d;
    logic [ACC_WIDTH-1:0] suma_q, suma_d;
    logic                 desborde_q, desborde_d;

    logic                 captura;
    logic                 pop;
    logic [ACC_WIDTH:0]   suma_ext;

    assign vacio = (cuenta_q == '0);
    assign lleno = (cuenta_q == CW'(DEPTH));

    // Push uses the registered full flag, so a same-cycle pop never makes room for it.
    assign captura = (state_q == ESPERA) && Done_Flag && !lleno;
    assign pop     = rd_en && !vacio;

    assign suma_ext = {1'b0, suma_q} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, producto};

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cuenta_d   = cuenta_q;
        suma_d     = suma_q;
        desborde_d = desborde_q;

        case (state_q)
            ESPERA:  if (captura) state_d = ACK;
            ACK:     if (!Done_Flag) state_d = ESPERA;
            default: state_d = ESPERA;
        endcase

        if (captura) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);

        if (captura && !pop)      cuenta_d = cuenta_q + CW'(1);
        else if (!captura && pop) cuenta_d = cuenta_q - CW'(1);

        // A clear coinciding with a capture restarts the sum from this product.
        if (clr_suma) begin
            suma_d     = captura ? {{(ACC_WIDTH - WIDTH){1'b0}}, producto} : '0;
            desborde_d = 1'b0;
        end else if (captura) begin
            suma_d     = suma_ext[ACC_WIDTH-1:0];
            desborde_d = desborde_q | suma_ext[ACC_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ESPERA;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cuenta_q   <= '0;
            suma_q     <= '0;
            desborde_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cuenta_q   <= cuenta_d;
            suma_q     <= suma_d;
            desborde_q <= desborde_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && captura) mem_q[wr_ptr_q] <= producto;
    end

    assign ack      = (state_q == ACK);
    assign dato     = vacio ? '0 : mem_q[rd_ptr_q];
    assign cuenta   = cuenta_q;
    assign suma     = suma_q;
    assign desborde = desborde_q;

endmodule
